// File: rtl/c2c_ser_pkg.sv
// Shared constants, state encoding and helper functions for the C2C word serializer.
package c2c_ser_pkg;
    localparam int WORD_W  = 21;
    localparam int BEAT_W  = 7;
    localparam int SOF_BIT = 7;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_B0   = 2'd1,
        ST_B1   = 2'd2,
        ST_B2   = 2'd3
    } state_e;

    // 7-bit slice carried by a beat state; the middle slice is order-independent.
    function automatic logic [BEAT_W-1:0] beat_slice(
        input logic [WORD_W-1:0] word,
        input state_e            st,
        input logic              lsb_first
    );
        logic [BEAT_W-1:0] slice;
        case (st)
            ST_B0:   slice = lsb_first ? word[6:0]   : word[20:14];
            ST_B1:   slice = word[13:7];
            ST_B2:   slice = lsb_first ? word[20:14] : word[6:0];
            default: slice = {BEAT_W{1'b0}};
        endcase
        return slice;
    endfunction

    function automatic logic even_parity(input logic [SOF_BIT:0] data);
        return ^data;
    endfunction
endpackage

// File: rtl/c2c_word_serializer_if.sv
// FIFO read port plus C2C transmit beat link seen by the word serializer.
interface c2c_word_serializer_if;
    import c2c_ser_pkg::*;

    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_rdata;
    logic              fifo_rden;
    logic [SOF_BIT:0]  tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_par;

    modport master (
        input  fifo_empty, fifo_rdata, tx_ready,
        output fifo_rden, tx_data, tx_valid, tx_par
    );

    modport slave (
        output fifo_empty, fifo_rdata, tx_ready,
        input  fifo_rden, tx_data, tx_valid, tx_par
    );
endinterface

// File: rtl/c2c_word_serializer.sv
// Pops 21-bit words from a FWFT FIFO and sends each as three 8-bit SOF-marked beats.
module c2c_word_serializer
    import c2c_ser_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1,
    parameter bit PAR_EN    = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    c2c_word_serializer_if.master link,
    output logic                  busy_o,
    output logic [CNT_W-1:0]      word_cnt_o
);
    state_e            state_q, state_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic [SOF_BIT:0]  tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              tx_par_q, tx_par_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic              last_beat_s;
    logic              load_s;

    // Pop qualifier; reset suppresses it so the FIFO never loses a word during RST.
    always_comb begin
        last_beat_s = (state_q == ST_B2) && link.tx_ready;
        load_s      = !rst_i && !link.fifo_empty
                      && ((state_q == ST_IDLE) || last_beat_s);
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load_s) state_d = ST_B0;
                else        state_d = ST_IDLE;
            end
            ST_B0: begin
                if (link.tx_ready) state_d = ST_B1;
                else               state_d = ST_B0;
            end
            ST_B1: begin
                if (link.tx_ready) state_d = ST_B2;
                else               state_d = ST_B1;
            end
            ST_B2: begin
                if (!link.tx_ready) state_d = ST_B2;
                else if (load_s)    state_d = ST_B0;
                else                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Beat outputs are precomputed from the next state so they leave registers.
    always_comb begin
        hold_d     = load_s ? link.fifo_rdata : hold_q;
        word_cnt_d = last_beat_s ? (word_cnt_q + CNT_W'(1)) : word_cnt_q;
        tx_valid_d = (state_d != ST_IDLE);
        tx_data_d  = {(state_d == ST_B0), beat_slice(hold_d, state_d, LSB_FIRST)};
        if (PAR_EN) begin
            tx_par_d = even_parity(tx_data_d);
        end else begin
            tx_par_d = 1'b0;
        end
    end

    // Holding register, beat output registers and word counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q     <= {WORD_W{1'b0}};
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            tx_par_q   <= 1'b0;
            word_cnt_q <= {CNT_W{1'b0}};
        end else begin
            hold_q     <= hold_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_par_q   <= tx_par_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign link.fifo_rden = load_s;
    assign link.tx_data   = tx_data_q;
    assign link.tx_valid  = tx_valid_q;
    assign link.tx_par    = tx_par_q;
    assign busy_o         = tx_valid_q;
    assign word_cnt_o     = word_cnt_q;
endmodule

// File: tb/tb_c2c_word_serializer.sv
// Bench for c2c_word_serializer: LSB-first/parity and MSB-first/no-parity instances share stimulus.
module tb_c2c_word_serializer;
    import c2c_ser_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty_v;
    logic [20:0] rdata_v;
    logic        ready_v;
    logic        busy_a, busy_m;
    logic [15:0] cnt_a, cnt_m;

    always #5 clk = ~clk;

    c2c_word_serializer_if if_a();
    c2c_word_serializer_if if_m();

    assign if_a.fifo_empty = fifo_empty_v;
    assign if_a.fifo_rdata = rdata_v;
    assign if_a.tx_ready   = ready_v;
    assign if_m.fifo_empty = fifo_empty_v;
    assign if_m.fifo_rdata = rdata_v;
    assign if_m.tx_ready   = ready_v;

    c2c_word_serializer #(.LSB_FIRST(1'b1), .PAR_EN(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst), .link(if_a.master), .busy_o(busy_a), .word_cnt_o(cnt_a));
    c2c_word_serializer #(.LSB_FIRST(1'b0), .PAR_EN(1'b0)) dut_m (
        .clk_i(clk), .rst_i(rst), .link(if_m.master), .busy_o(busy_m), .word_cnt_o(cnt_m));

    // Reference: FIFO content, expected beat streams {last, par, data}, word count.
    logic [20:0] fifo_q[$];
    logic [9:0]  qa[$];
    logic [9:0]  qm[$];
    logic [15:0] exp_cnt;
    int          n_cmp;
    int          n_fail;

    logic       o_rden, o_rden_m, o_valid_a, o_valid_m, o_par_a, o_par_m, acc;
    logic [7:0] o_data_a, o_data_m;
    logic [9:0] e_a, e_m;

    function automatic logic [9:0] mk_beat(input logic [20:0] w, input int idx,
                                           input bit lsb, input bit par_en);
        int         sh;
        logic [6:0] s;
        logic [7:0] d;
        sh = lsb ? 7 * idx : 7 * (2 - idx);
        s  = 7'((w >> sh) & 21'h7F);
        d  = {(idx == 0), s};
        return {(idx == 2), (par_en ? ^d : 1'b0), d};
    endfunction

    task automatic drive_cycle(input bit rdy, input bit rst_v);
        logic [20:0] w;
        @(negedge clk);
        rst          = rst_v;
        ready_v      = rdy;
        fifo_empty_v = (fifo_q.size() == 0);
        rdata_v      = fifo_empty_v ? 21'($urandom) : fifo_q[0];
        #1;
        o_rden    = if_a.fifo_rden;  o_rden_m  = if_m.fifo_rden;
        o_valid_a = if_a.tx_valid;   o_valid_m = if_m.tx_valid;
        o_data_a  = if_a.tx_data;    o_data_m  = if_m.tx_data;
        o_par_a   = if_a.tx_par;     o_par_m   = if_m.tx_par;
        acc       = o_valid_a && rdy;
        if (rst_v) begin
            qa.delete(); qm.delete(); exp_cnt = 16'd0;
        end else begin
            if (acc) begin
                e_a = (qa.size() > 0) ? qa.pop_front() : 10'bx;
                e_m = (qm.size() > 0) ? qm.pop_front() : 10'bx;
                if (e_a[9] === 1'b1) exp_cnt = exp_cnt + 16'd1;
            end
            if (o_rden && fifo_q.size() > 0) begin
                w = fifo_q.pop_front();
                for (int i = 0; i < 3; i++) begin
                    qa.push_back(mk_beat(w, i, 1'b1, 1'b1));
                    qm.push_back(mk_beat(w, i, 1'b0, 1'b0));
                end
            end
        end
    endtask

    // Runs until FIFO and expected beats are drained; checks beats, stalls, pop legality.
    task automatic run_scoreboard(input int budget, input int rdy_pct);
        bit         rdy, prev_stall;
        logic [7:0] pa, pm;
        logic       ppa;
        int         cyc;
        prev_stall = 1'b0; pa = 8'h00; pm = 8'h00; ppa = 1'b0; cyc = 0;
        while ((fifo_q.size() != 0 || qa.size() != 0) && cyc < budget) begin
            rdy = ($urandom_range(99) < rdy_pct);
            drive_cycle(rdy, 1'b0);
            n_cmp++;
            if (fifo_empty_v && (o_rden || o_rden_m)) begin
                n_fail++; $display("FAIL rden_when_empty: got %0b/%0b want 0", o_rden, o_rden_m);
            end
            if (prev_stall) begin
                n_cmp++;
                if (o_valid_a !== 1'b1 || o_data_a !== pa || o_par_a !== ppa || o_data_m !== pm) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v%0b %h/%0b m%h want v1 %h/%0b m%h",
                             o_valid_a, o_data_a, o_par_a, o_data_m, pa, ppa, pm);
                end
            end
            if (acc) begin
                n_cmp++;
                if ({o_par_a, o_data_a} !== e_a[8:0] || {o_par_m, o_data_m} !== e_m[8:0]) begin
                    n_fail++;
                    $display("FAIL beat: got a=%h m=%h want a=%h m=%h",
                             {o_par_a, o_data_a}, {o_par_m, o_data_m}, e_a[8:0], e_m[8:0]);
                end
            end
            prev_stall = o_valid_a && !rdy;
            pa = o_data_a; pm = o_data_m; ppa = o_par_a;
            cyc++;
        end
        n_cmp++;
        if (cyc >= budget) begin
            n_fail++; $display("FAIL drain_timeout: got %0d cycles want < %0d", cyc, budget);
        end
        drive_cycle(1'b0, 1'b0);
        n_cmp++;
        if (cnt_a !== exp_cnt || cnt_m !== exp_cnt || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL word_cnt: got %h/%h busy %0b want %h busy 0", cnt_a, cnt_m, busy_a, exp_cnt);
        end
    endtask

    task automatic test_reset();
        fifo_q.push_back(21'($urandom));
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b1);
            n_cmp++;
            if (o_rden !== 1'b0 || o_rden_m !== 1'b0) begin
                n_fail++; $display("FAIL reset_rden: got %0b/%0b want 0", o_rden, o_rden_m);
            end
        end
        drive_cycle(1'b0, 1'b0);
        n_cmp++;
        if (o_valid_a !== 1'b0 || o_data_a !== 8'h00 || o_par_a !== 1'b0 || busy_a !== 1'b0
            || cnt_a !== 16'd0 || o_valid_m !== 1'b0 || o_data_m !== 8'h00 || cnt_m !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_values: got v%0b d%h p%0b b%0b c%h m:v%0b d%h c%h want all 0",
                     o_valid_a, o_data_a, o_par_a, busy_a, cnt_a, o_valid_m, o_data_m, cnt_m);
        end
        n_cmp++;
        if (o_rden !== 1'b1) begin
            n_fail++; $display("FAIL idle_load_latency: got rden %0b want 1", o_rden);
        end
        drive_cycle(1'b0, 1'b0);
        n_cmp++;
        if (o_valid_a !== 1'b1 || o_data_a[7] !== 1'b1) begin
            n_fail++; $display("FAIL first_b0: got v%0b sof%0b want v1 sof1", o_valid_a, o_data_a[7]);
        end
        run_scoreboard(60, 100);
    endtask

    task automatic test_single();
        logic [7:0] want_a[5], want_m[5], da[5], dm[5];
        logic       want_p[5], pa[5], pm[5], rd[5];
        want_a = '{8'h00, 8'hDE, 8'h79, 8'h6A, 8'h00};
        want_p = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        want_m = '{8'h00, 8'hEA, 8'h79, 8'h5E, 8'h00};
        fifo_q.push_back(21'h1ABCDE);
        for (int c = 0; c < 5; c++) begin
            drive_cycle(1'b1, 1'b0);
            da[c] = o_data_a; dm[c] = o_data_m; pa[c] = o_par_a; pm[c] = o_par_m; rd[c] = o_rden;
        end
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (da[c] !== want_a[c] || pa[c] !== want_p[c] || dm[c] !== want_m[c] || pm[c] !== 1'b0) begin
                n_fail++;
                $display("FAIL single_beat%0d: got %h/%0b m%h/%0b want %h/%0b m%h/0",
                         c, da[c], pa[c], dm[c], pm[c], want_a[c], want_p[c], want_m[c]);
            end
        end
        n_cmp++;
        if ({rd[0], rd[1], rd[2], rd[3], rd[4]} !== 5'b10000) begin
            n_fail++; $display("FAIL single_rden: got %b want 10000", {rd[0], rd[1], rd[2], rd[3], rd[4]});
        end
        n_cmp++;
        if (cnt_a !== exp_cnt) begin
            n_fail++; $display("FAIL single_cnt: got %h want %h", cnt_a, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit rdy_pat[8];
        int extra;
        rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        extra = 0;
        fifo_q.push_back(21'h1ABCDE);
        fifo_q.push_back(21'($urandom));
        for (int c = 0; c < 8; c++) begin
            drive_cycle(rdy_pat[c], 1'b0);
            if (c >= 1 && c <= 6 && o_rden) extra++;
            if (c >= 2 && c <= 6) begin
                n_cmp++;
                if (o_valid_a !== 1'b1 || o_data_a !== 8'h79 || o_par_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_hold%0d: got v%0b %h/%0b want v1 79/1", c, o_valid_a, o_data_a, o_par_a);
                end
            end
            if (acc) begin
                n_cmp++;
                if ({o_par_a, o_data_a} !== e_a[8:0] || {o_par_m, o_data_m} !== e_m[8:0]) begin
                    n_fail++;
                    $display("FAIL bp_beat%0d: got %h m%h want %h m%h", c,
                             {o_par_a, o_data_a}, {o_par_m, o_data_m}, e_a[8:0], e_m[8:0]);
                end
            end
        end
        n_cmp++;
        if (extra !== 0 || o_rden !== 1'b1) begin
            n_fail++; $display("FAIL bp_rden: got extra %0d b2 %0b want extra 0 b2 1", extra, o_rden);
        end
        run_scoreboard(60, 100);
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) fifo_q.push_back(21'($urandom));
        for (int c = 0; c < 14; c++) begin
            drive_cycle(1'b1, 1'b0);
            n_cmp++;
            if (o_rden !== (c % 3 == 0 && c <= 9) || o_valid_a !== (c >= 1 && c <= 12)
                || busy_a !== (c >= 1 && c <= 12)
                || o_data_a[7] !== (c >= 1 && c <= 12 && (c - 1) % 3 == 0)) begin
                n_fail++;
                $display("FAIL stream_cyc%0d: got rden%0b v%0b busy%0b sof%0b", c, o_rden, o_valid_a,
                         busy_a, o_data_a[7]);
            end
            if (acc) begin
                n_cmp++;
                if ({o_par_a, o_data_a} !== e_a[8:0] || {o_par_m, o_data_m} !== e_m[8:0]) begin
                    n_fail++;
                    $display("FAIL stream_beat%0d: got %h m%h want %h m%h", c,
                             {o_par_a, o_data_a}, {o_par_m, o_data_m}, e_a[8:0], e_m[8:0]);
                end
            end
        end
        n_cmp++;
        if (cnt_a !== exp_cnt || cnt_m !== exp_cnt) begin
            n_fail++; $display("FAIL stream_cnt: got %h/%h want %h", cnt_a, cnt_m, exp_cnt);
        end
    endtask

    task automatic test_empty_boundary();
        int  cyc;
        bit  done;
        for (int c = 0; c < 10; c++) begin
            drive_cycle(1'($urandom), 1'b0);
            n_cmp++;
            if (o_rden !== 1'b0 || o_valid_a !== 1'b0 || o_valid_m !== 1'b0) begin
                n_fail++; $display("FAIL empty_idle: got rden%0b v%0b/%0b want 0", o_rden, o_valid_a, o_valid_m);
            end
        end
        fifo_q.push_back(21'($urandom));
        cyc = 0; done = 1'b0;
        while (!done && cyc < 10) begin
            drive_cycle(1'b1, 1'b0);
            done = acc && e_a[9];
            cyc++;
        end
        n_cmp++;
        if (!done || o_rden !== 1'b0) begin
            n_fail++; $display("FAIL empty_b2: got done%0b rden%0b want done1 rden0", done, o_rden);
        end
        fifo_q.push_back(21'($urandom));
        drive_cycle(1'b1, 1'b0);
        n_cmp++;
        if (o_valid_a !== 1'b0 || o_rden !== 1'b1) begin
            n_fail++; $display("FAIL empty_gap: got v%0b rden%0b want v0 rden1", o_valid_a, o_rden);
        end
        drive_cycle(1'b1, 1'b0);
        n_cmp++;
        if (o_valid_a !== 1'b1 || o_data_a[7] !== 1'b1 || {o_par_a, o_data_a} !== e_a[8:0]) begin
            n_fail++; $display("FAIL empty_resume: got v%0b %h want v1 %h", o_valid_a, {o_par_a, o_data_a}, e_a[8:0]);
        end
        run_scoreboard(60, 100);
    endtask

    task automatic test_reset_mid_word();
        fifo_q.push_back(21'($urandom));
        fifo_q.push_back(21'($urandom));
        drive_cycle(1'b1, 1'b0);
        drive_cycle(1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1);
        n_cmp++;
        if (o_valid_a !== 1'b1 || o_data_a[7] !== 1'b0) begin
            n_fail++; $display("FAIL mid_in_b1: got v%0b sof%0b want v1 sof0", o_valid_a, o_data_a[7]);
        end
        drive_cycle(1'b1, 1'b0);
        n_cmp++;
        if (o_valid_a !== 1'b0 || o_data_a !== 8'h00 || o_par_a !== 1'b0 || busy_a !== 1'b0
            || cnt_a !== 16'd0 || cnt_m !== 16'd0 || o_rden !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: got v%0b d%h p%0b b%0b c%h/%h rden%0b want 0s rden1",
                     o_valid_a, o_data_a, o_par_a, busy_a, cnt_a, cnt_m, o_rden);
        end
        drive_cycle(1'b1, 1'b0);
        n_cmp++;
        if (o_valid_a !== 1'b1 || o_data_a[7] !== 1'b1 || {o_par_a, o_data_a} !== e_a[8:0]
            || {o_par_m, o_data_m} !== e_m[8:0]) begin
            n_fail++;
            $display("FAIL mid_next_b0: got %h m%h want %h m%h",
                     {o_par_a, o_data_a}, {o_par_m, o_data_m}, e_a[8:0], e_m[8:0]);
        end
        run_scoreboard(60, 100);
    endtask

    task automatic test_msb_first_wrap();
        logic [7:0] want_m[3], dm[3];
        want_m = '{8'hEA, 8'h79, 8'h5E};
        @(negedge clk);
        force dut_a.word_cnt_q = 16'hFFFF;
        force dut_m.word_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut_a.word_cnt_q;
        release dut_m.word_cnt_q;
        exp_cnt = 16'hFFFF;
        fifo_q.push_back(21'h1ABCDE);
        drive_cycle(1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            drive_cycle(1'b1, 1'b0);
            dm[c] = o_data_m;
        end
        drive_cycle(1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (dm[c] !== want_m[c]) begin
                n_fail++; $display("FAIL msb_beat%0d: got %h want %h", c, dm[c], want_m[c]);
            end
        end
        n_cmp++;
        if (cnt_m !== 16'h0000 || cnt_a !== 16'h0000 || exp_cnt !== 16'h0000) begin
            n_fail++; $display("FAIL cnt_wrap: got %h/%h want 0000", cnt_m, cnt_a);
        end
    endtask

    task automatic test_random_backpressure();
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 8; i++) fifo_q.push_back(21'($urandom));
            run_scoreboard(400, 60);
        end
    endtask

    initial begin
        rst = 1'b1; fifo_empty_v = 1'b1; rdata_v = 21'd0; ready_v = 1'b0;
        exp_cnt = 16'd0; n_cmp = 0; n_fail = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_empty_boundary();
        test_reset_mid_word();
        test_random_backpressure();
        test_msb_first_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
